// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES definitions used by the input stage and by the later
// final-permutation and output stages.
//   des_block_t  : 64-bit DES block, DES bit 1 held in vector bit 63
//   des_key56_t  : 56-bit PC-1 key (C0 in DES bits 1..28, D0 in 29..56)
//   des_state_t  : input-stage FSM states
//   IP_TABLE     : Initial Permutation, entry i = source bit of output bit i+1
//   PC1_TABLE    : Permuted Choice 1, entry i = source bit of output bit i+1
// -----------------------------------------------------------------------------
package des_pkg;

    typedef logic [63:0] des_block_t;
    typedef logic [55:0] des_key56_t;

    typedef enum logic [2:0] {
        KEY_HI,
        KEY_LO,
        TXT_HI,
        TXT_LO,
        OUT
    } des_state_t;

    // Table entries use DES numbering (1 = MSB of the source word).
    localparam int IP_TABLE [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9, 1,
        58, 50, 42, 34, 26, 18, 10, 2,
        59, 51, 43, 35, 27, 19, 11, 3,
        60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7,
        62, 54, 46, 38, 30, 22, 14, 6,
        61, 53, 45, 37, 29, 21, 13, 5,
        28, 20, 12, 4
    };

endpackage

// File: rtl/des_input_stage_if.sv
// -----------------------------------------------------------------------------
// des_input_stage_if
// Bundles the word stream into the DES input stage and the block stream
// out of it.
//   s_data/s_valid/s_key_keep/s_ready : 32-bit word stream (DES bit 1 = MSB)
//   m_ip_text/m_key/m_parity_err      : permuted block handed to the round core
//   m_valid/m_ready                   : block handshake
// Modports:
//   slave  : the input stage itself (accepts words, produces blocks)
//   master : its environment (sends words, consumes blocks)
// -----------------------------------------------------------------------------
interface des_input_stage_if;
    import des_pkg::*;

    logic [31:0] s_data;
    logic        s_valid;
    logic        s_key_keep;
    logic        s_ready;

    des_block_t  m_ip_text;
    des_key56_t  m_key;
    logic        m_parity_err;
    logic        m_valid;
    logic        m_ready;

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_key_keep,
        output s_ready,
        output m_ip_text,
        output m_key,
        output m_parity_err,
        output m_valid,
        input  m_ready
    );

    modport master (
        output s_data,
        output s_valid,
        output s_key_keep,
        input  s_ready,
        input  m_ip_text,
        input  m_key,
        input  m_parity_err,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/des_perm_ip_pc1.sv
// -----------------------------------------------------------------------------
// des_perm_ip_pc1
// Purely combinational: Initial Permutation of the text block, PC-1 of the
// key, and the odd-parity check over the eight key bytes.
//   text_in    : 64-bit plaintext, DES bit 1 in [63]
//   key_in     : 64-bit key including parity bits, DES bit 1 in [63]
//   ip_out     : IP(text_in)
//   pc1_out    : PC-1(key_in) = {C0, D0}
//   parity_err : 1 when any key byte has even parity (0 if CHECK_PARITY = 0)
// -----------------------------------------------------------------------------
module des_perm_ip_pc1
    import des_pkg::*;
#(
    parameter bit CHECK_PARITY = 1'b1
)
(
    input  des_block_t text_in,
    input  des_block_t key_in,
    output des_block_t ip_out,
    output des_key56_t pc1_out,
    output logic       parity_err
);

    logic [7:0] byte_bad;

    // DES bit n lives at vector index (width - n), so output bit i+1 of
    // each table lands at index (width - 1 - i).
    for (genvar i = 0; i < 64; i++) begin : g_ip
        assign ip_out[63 - i] = text_in[64 - IP_TABLE[i]];
    end

    // PC-1 never selects bits 8, 16, ..., 64, so the parity bits drop out
    // of the key here.
    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign pc1_out[55 - i] = key_in[64 - PC1_TABLE[i]];
    end

    // A valid DES key byte has odd parity; flag each byte whose XOR is 0.
    for (genvar b = 0; b < 8; b++) begin : g_parity
        assign byte_bad[b] = ~(^key_in[63 - 8 * b -: 8]);
    end

    assign parity_err = CHECK_PARITY ? (|byte_bad) : 1'b0;

endmodule

// File: rtl/des_input_stage.sv
// -----------------------------------------------------------------------------
// des_input_stage
// Front end of the DES datapath. Collects key and plaintext from a 32-bit
// word stream (key hi, key lo, text hi, text lo), applies IP and PC-1,
// checks key parity and presents the result through a registered
// valid/ready output. A transaction starting with s_key_keep = 1 reuses
// the stored key and sends only the two text words.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : des_input_stage_if.slave (word stream in, block stream out)
// -----------------------------------------------------------------------------
module des_input_stage
    import des_pkg::*;
#(
    parameter bit CHECK_PARITY = 1'b1
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    des_input_stage_if.slave        bus
);

    des_state_t state;
    des_state_t state_next;

    logic       beat;
    logic       keep_hit;
    logic       key_stored;

    des_block_t key_q;
    logic [31:0] text_hi_q;

    des_block_t perm_ip;
    des_key56_t perm_key;
    logic       perm_err;

    des_block_t ip_q;
    des_key56_t key56_q;
    logic       perr_q;

    assign beat     = bus.s_valid && bus.s_ready;
    assign keep_hit = bus.s_key_keep && key_stored;

    // The last text word goes straight from the bus into the permutation
    // so the block is registered on the same edge the word is accepted.
    des_perm_ip_pc1 #(
        .CHECK_PARITY (CHECK_PARITY)
    ) u_perm (
        .text_in    ({text_hi_q, bus.s_data}),
        .key_in     (key_q),
        .ip_out     (perm_ip),
        .pc1_out    (perm_key),
        .parity_err (perm_err)
    );

    // FSM state register; reset drops any partial transaction and, since
    // m_valid decodes OUT, also clears m_valid on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= KEY_HI;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs. The stage advances one state per
    // accepted word and waits in OUT until the block is taken; s_ready is
    // low in OUT so no word can slip in on the transfer cycle.
    always_comb begin
        state_next  = state;
        bus.s_ready = 1'b1;
        bus.m_valid = 1'b0;
        case (state)
            KEY_HI: begin
                if (beat) begin
                    state_next = keep_hit ? TXT_LO : KEY_LO;
                end
            end
            KEY_LO: begin
                if (beat) begin
                    state_next = TXT_HI;
                end
            end
            TXT_HI: begin
                if (beat) begin
                    state_next = TXT_LO;
                end
            end
            TXT_LO: begin
                if (beat) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                bus.s_ready = 1'b0;
                bus.m_valid = 1'b1;
                if (bus.m_ready) begin
                    state_next = KEY_HI;
                end
            end
            default: begin
                state_next = KEY_HI;
            end
        endcase
    end

    // Word capture and output register. In KEY_HI a kept-key transaction
    // routes the word into the text register and leaves the stored key
    // untouched, so the block recomputes the same PC-1 and parity result.
    // The key only counts as stored once both key words have arrived.
    // Output registers load only on the final text word, which keeps them
    // stable for as long as the block is held in OUT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_q      <= '0;
            text_hi_q  <= '0;
            key_stored <= 1'b0;
            ip_q       <= '0;
            key56_q    <= '0;
            perr_q     <= 1'b0;
        end else if (beat) begin
            case (state)
                KEY_HI: begin
                    if (keep_hit) begin
                        text_hi_q <= bus.s_data;
                    end else begin
                        key_q[63:32] <= bus.s_data;
                    end
                end
                KEY_LO: begin
                    key_q[31:0] <= bus.s_data;
                    key_stored  <= 1'b1;
                end
                TXT_HI: begin
                    text_hi_q <= bus.s_data;
                end
                TXT_LO: begin
                    ip_q    <= perm_ip;
                    key56_q <= perm_key;
                    perr_q  <= perm_err;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.m_ip_text    = ip_q;
    assign bus.m_key        = key56_q;
    assign bus.m_parity_err = perr_q;

endmodule
